// File: rtl/mem_pkg.sv
// Shared memory-side definitions: op/size encodings, the BRAM address window,
// and the data-port arbiter state type.
package mem_pkg;

  typedef enum logic [1:0] {
    OP_DISABLE   = 2'b00,
    OP_READ_SEXT = 2'b01,
    OP_READ_ZEXT = 2'b10,
    OP_WRITE     = 2'b11
  } mem_op_e;

  typedef enum logic [1:0] {
    SZ_BYTE     = 2'b00,
    SZ_HALFWORD = 2'b01,
    SZ_WORD     = 2'b10
  } mem_size_e;

  localparam logic [31:0] CPU_BRAM_START = 32'h0000_0000;
  localparam logic [31:0] CPU_BRAM_END   = 32'h007F_FF00;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_ISSUE = 2'b01,
    ARB_RESP  = 2'b10
  } arb_state_e;

  // Offset form stays well-defined even when lo is zero.
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] lo,
                                     input logic [31:0] hi);
    return (addr - lo) <= (hi - lo);
  endfunction

endpackage

// File: rtl/dmem_wstrb_gen.sv
// Byte-lane strobe and lane-swapped write-data generation for the data BRAM
// port; lane 3 ([31:24]) holds the byte at address offset 0.
module dmem_wstrb_gen #(
  parameter logic [1:0] BYTE     = 2'b00,
  parameter logic [1:0] HALFWORD = 2'b01,
  parameter logic [1:0] WORD     = 2'b10
) (
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  mem_size,
  input  logic [31:0] wdata,
  input  logic        in_range,
  output logic [3:0]  web,
  output logic [31:0] dinb,
  output logic        misaligned
);

  logic [3:0] lanes;

  always_comb begin
    lanes      = '0;
    dinb       = '0;
    misaligned = 1'b0;
    case (mem_size)
      BYTE: begin
        lanes = 4'b1000 >> addr_lo;
        dinb  = {4{wdata[7:0]}};
      end
      HALFWORD: begin
        misaligned = addr_lo[0];
        if (addr_lo == 2'b00)      lanes = 4'b1100;
        else if (addr_lo == 2'b10) lanes = 4'b0011;
        dinb = {2{wdata[7:0], wdata[15:8]}};
      end
      WORD: begin
        misaligned = (addr_lo != 2'b00);
        if (addr_lo == 2'b00) lanes = 4'b1111;
        dinb = {wdata[7:0], wdata[15:8], wdata[23:16], wdata[31:24]};
      end
      default: ;
    endcase
    web = (misaligned || !in_range) ? 4'b0000 : lanes;
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter and sequencer sharing data BRAM port B between the CPU
// load/store stage (requester 0) and the host loader (requester 1).
import mem_pkg::*;

module dmem_port_arbiter #(
  parameter logic [1:0]  MEM_DISABLE    = 2'b00,
  parameter logic [1:0]  MEM_READ_SEXT  = 2'b01,
  parameter logic [1:0]  MEM_READ_ZEXT  = 2'b10,
  parameter logic [1:0]  MEM_WRITE      = 2'b11,
  parameter logic [1:0]  BYTE           = 2'b00,
  parameter logic [1:0]  HALFWORD       = 2'b01,
  parameter logic [1:0]  WORD           = 2'b10,
  parameter logic [31:0] CPU_BRAM_START = mem_pkg::CPU_BRAM_START,
  parameter logic [31:0] CPU_BRAM_END   = mem_pkg::CPU_BRAM_END
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [1:0]  memOp0,
  input  logic [1:0]  memOp1,
  input  logic [1:0]  memSize0,
  input  logic [1:0]  memSize1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        ack0,
  output logic        ack1,
  output logic        err0,
  output logic        err1,
  output logic        enb,
  output logic [3:0]  web,
  output logic [31:0] addrb,
  output logic [31:0] dinb,
  output logic [1:0]  memOp,
  output logic [1:0]  memSize
);

  arb_state_e  state_q, state_d;
  logic        last_q, last_d;
  logic        win_q, win_d;
  logic        err_q, err_d;
  logic        enb_q, enb_d;
  logic [3:0]  web_q, web_d;
  logic [31:0] addrb_q, addrb_d;
  logic [31:0] dinb_q, dinb_d;
  logic [1:0]  op_q, op_d;
  logic [1:0]  size_q, size_d;

  logic        v0, v1, sel1;
  logic [31:0] addr_m, wdata_m;
  logic [1:0]  op_m, size_m;
  logic        in_range;
  logic [3:0]  web_w;
  logic [31:0] dinb_w;
  logic        mis_w;
  logic        ack;

  // Requester 1 wins only when alone or when requester 0 was served last.
  always_comb begin
    v0       = req0 && (memOp0 != MEM_DISABLE);
    v1       = req1 && (memOp1 != MEM_DISABLE);
    sel1     = v1 && (!v0 || !last_q);
    addr_m   = sel1 ? addr1    : addr0;
    op_m     = sel1 ? memOp1   : memOp0;
    size_m   = sel1 ? memSize1 : memSize0;
    wdata_m  = sel1 ? wdata1   : wdata0;
    in_range = in_window(addr_m, CPU_BRAM_START, CPU_BRAM_END);
  end

  dmem_wstrb_gen #(
    .BYTE     (BYTE),
    .HALFWORD (HALFWORD),
    .WORD     (WORD)
  ) u_wstrb (
    .addr_lo    (addr_m[1:0]),
    .mem_size   (size_m),
    .wdata      (wdata_m),
    .in_range   (in_range),
    .web        (web_w),
    .dinb       (dinb_w),
    .misaligned (mis_w)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    win_d   = win_q;
    err_d   = err_q;
    enb_d   = enb_q;
    web_d   = web_q;
    addrb_d = addrb_q;
    dinb_d  = dinb_q;
    op_d    = op_q;
    size_d  = size_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    ack     = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        // Grant is suppressed while reset is held so no accept pulse escapes.
        if ((v0 || v1) && !reset) begin
          gnt0    = !sel1;
          gnt1    = sel1;
          last_d  = sel1;
          win_d   = sel1;
          addrb_d = addr_m;
          op_d    = op_m;
          size_d  = size_m;
          dinb_d  = dinb_w;
          web_d   = (op_m == MEM_WRITE) ? web_w : 4'b0000;
          err_d   = mis_w;
          enb_d   = 1'b1;
          state_d = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        enb_d = 1'b0;
        web_d = '0;
        if (op_q == MEM_WRITE) begin
          ack     = 1'b1;
          state_d = ARB_IDLE;
        end else if ((op_q == MEM_READ_SEXT) || (op_q == MEM_READ_ZEXT)) begin
          state_d = ARB_RESP;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_RESP: begin
        ack     = 1'b1;
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      last_q  <= 1'b1;
      win_q   <= 1'b0;
      err_q   <= 1'b0;
      enb_q   <= 1'b0;
      web_q   <= '0;
      addrb_q <= '0;
      dinb_q  <= '0;
      op_q    <= MEM_DISABLE;
      size_q  <= BYTE;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      win_q   <= win_d;
      err_q   <= err_d;
      enb_q   <= enb_d;
      web_q   <= web_d;
      addrb_q <= addrb_d;
      dinb_q  <= dinb_d;
      op_q    <= op_d;
      size_q  <= size_d;
    end
  end

  assign ack0    = ack && !win_q;
  assign ack1    = ack && win_q;
  assign err0    = ack && !win_q && err_q;
  assign err1    = ack && win_q && err_q;
  assign enb     = enb_q;
  assign web     = web_q;
  assign addrb   = addrb_q;
  assign dinb    = dinb_q;
  assign memOp   = op_q;
  assign memSize = size_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: per-cycle comparison against a transaction-level
// model, a small BRAM behind port B, and directed scenarios with literal values.
module tb_dmem_port_arbiter;

  localparam logic [1:0]  OPW = 2'b11, ORS = 2'b01;
  localparam logic [1:0]  SB = 2'b00, SH = 2'b01, SW = 2'b10;
  localparam logic [31:0] BRAM_END = 32'h007F_FF00;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, req0, req1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [1:0]  memOp0, memOp1, memSize0, memSize1;
  logic        gnt0, gnt1, ack0, ack1, err0, err1, enb;
  logic [3:0]  web;
  logic [31:0] addrb, dinb;
  logic [1:0]  memOp, memSize;

  dmem_port_arbiter #(.CPU_BRAM_END(BRAM_END)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .memOp0(memOp0), .memOp1(memOp1), .memSize0(memSize0), .memSize1(memSize1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .memOp(memOp), .memSize(memSize)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0, nerr = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic timeout_fail(input string nm);
    nvec++;
    nerr++;
    $display("FAIL %s @cyc %0d: got no response, expected one within bound", nm, cyc);
  endtask

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // Port-B BRAM, read-first, one registered read cycle.
  logic [31:0] bram [64] = '{default: '0};
  logic [31:0] dout_q = '0;
  always @(posedge clk) begin
    if (enb) begin
      dout_q <= bram[addrb[7:2]];
      for (int l = 0; l < 4; l++)
        if (web[l]) bram[addrb[7:2]][8*l +: 8] <= dinb[8*l +: 8];
    end
  end

  // ---------------- transaction-level model ----------------
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == SB) ? 1 : (sz == SH) ? 2 : 4;
  endfunction

  function automatic logic mis_f(input logic [31:0] a, input logic [1:0] sz);
    return (int'(a[1:0]) % nbytes(sz)) != 0;
  endfunction

  function automatic logic [3:0] web_f(input logic [31:0] a, input logic [1:0] op,
                                       input logic [1:0] sz);
    logic [3:0] w = '0;
    if (op == OPW && !mis_f(a, sz) && a <= BRAM_END)
      for (int k = 0; k < nbytes(sz); k++) w[3 - (int'(a[1:0]) + k)] = 1'b1;
    return w;
  endfunction

  function automatic logic [31:0] dinb_f(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] d;
    for (int l = 0; l < 4; l++) d[8*l +: 8] = wd[8*((3 - l) % nbytes(sz)) +: 8];
    return d;
  endfunction

  logic [7:0] m_mem [logic [31:0]];
  function automatic logic [7:0] mbyte(input logic [31:0] a);
    return m_mem.exists(a) ? m_mem[a] : 8'h00;
  endfunction

  int          m_gcyc, m_ack_cyc, m_free_at, m_ack_id;
  logic        m_err, m_read, m_last;
  logic [3:0]  m_web;
  logic [31:0] m_addrb, m_dinb;
  logic [1:0]  m_op, m_size;
  bit          run_chk = 0;

  always @(negedge clk) begin : compare
    logic v0, v1;
    int w, c;
    logic [31:0] a, wd;
    logic [1:0] op, sz;
    if (run_chk) begin
      c = cyc;
      if (reset) begin
        m_free_at = 0; m_gcyc = -10; m_ack_cyc = -10; m_ack_id = 0; m_last = 1'b1;
        m_err = 0; m_read = 0; m_web = '0; m_addrb = '0; m_dinb = '0; m_op = '0; m_size = '0;
        chk("rst_gnt", {gnt0, gnt1}, 0);
        chk("rst_ack", {ack0, ack1, err0, err1}, 0);
        chk("rst_enb_web", {enb, web}, 0);
        chk("rst_addrb", addrb, 0);
        chk("rst_dinb", dinb, 0);
        chk("rst_op_size", {memOp, memSize}, 0);
      end else begin
        v0 = req0 && memOp0 != 2'b00;
        v1 = req1 && memOp1 != 2'b00;
        w = -1;
        if (c >= m_free_at && (v0 || v1))
          w = (v0 && v1) ? (m_last ? 0 : 1) : (v0 ? 0 : 1);
        chk("gnt0", gnt0, w == 0);
        chk("gnt1", gnt1, w == 1);
        chk("ack0", ack0, c == m_ack_cyc && m_ack_id == 0);
        chk("ack1", ack1, c == m_ack_cyc && m_ack_id == 1);
        chk("err0", err0, c == m_ack_cyc && m_ack_id == 0 && m_err);
        chk("err1", err1, c == m_ack_cyc && m_ack_id == 1 && m_err);
        chk("enb", enb, c == m_gcyc + 1);
        chk("web", web, (c == m_gcyc + 1) ? m_web : 4'b0000);
        chk("addrb", addrb, m_addrb);
        chk("dinb", dinb, m_dinb);
        chk("memOp", memOp, m_op);
        chk("memSize", memSize, m_size);
        if (c == m_ack_cyc && m_read && m_size == SW && !m_err)
          chk("dout", bswap(dout_q), {mbyte(m_addrb + 3), mbyte(m_addrb + 2),
                                      mbyte(m_addrb + 1), mbyte(m_addrb)});
        if (w >= 0) begin
          a  = (w == 1) ? addr1 : addr0;
          op = (w == 1) ? memOp1 : memOp0;
          sz = (w == 1) ? memSize1 : memSize0;
          wd = (w == 1) ? wdata1 : wdata0;
          m_last    = (w == 1);
          m_ack_id  = w;
          m_gcyc    = c;
          m_read    = (op != OPW);
          m_ack_cyc = c + (m_read ? 2 : 1);
          m_free_at = m_ack_cyc + 1;
          m_err     = mis_f(a, sz);
          m_web     = web_f(a, op, sz);
          m_addrb   = a;
          m_dinb    = dinb_f(sz, wd);
          m_op      = op;
          m_size    = sz;
          if (m_web != 0)
            for (int k = 0; k < nbytes(sz); k++) m_mem[a + k] = wd[8*k +: 8];
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  logic [3:0]  t_web;
  logic [31:0] t_dinb, t_dout;

  task automatic txn(input int id, input logic [31:0] a, input logic [1:0] op,
                     input logic [1:0] sz, input logic [31:0] wd,
                     output int lat, output logic e);
    int g = -1;
    lat = -1;
    e = 1'b0;
    if (id == 0) begin addr0 = a; memOp0 = op; memSize0 = sz; wdata0 = wd; req0 = 1'b1; end
    else         begin addr1 = a; memOp1 = op; memSize1 = sz; wdata1 = wd; req1 = 1'b1; end
    for (int i = 0; i < 20 && g < 0; i++) begin
      @(negedge clk);
      if ((id == 0) ? gnt0 : gnt1) g = cyc;
    end
    @(posedge clk); #1;
    if (id == 0) req0 = 1'b0; else req1 = 1'b0;
    if (g < 0) begin
      timeout_fail("gnt_wait");
      return;
    end
    for (int i = 0; i < 10 && lat < 0; i++) begin
      @(negedge clk);
      if (cyc == g + 1) begin t_web = web; t_dinb = dinb; end
      if ((id == 0) ? ack0 : ack1) begin
        lat = cyc - g;
        e = (id == 0) ? err0 : err1;
        t_dout = bswap(dout_q);
      end
    end
    if (lat < 0) timeout_fail("ack_wait");
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int lat;
    logic e;
    int order[$];
    bit got;
    reset = 1'b0; req0 = 0; req1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    memOp0 = '0; memOp1 = '0; memSize0 = '0; memSize1 = '0;
    #1 reset = 1'b1;
    run_chk = 1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Word write then read back.
    txn(0, 32'h10, OPW, SW, 32'h1122_3344, lat, e);
    chk("wr_lat", lat, 1);
    chk("wr_web", t_web, 4'b1111);
    chk("wr_dinb", t_dinb, 32'h4433_2211);
    chk("wr_err", e, 0);
    txn(0, 32'h10, ORS, SW, 32'h0, lat, e);
    chk("rd_lat", lat, 2);
    chk("rd_dout", t_dout, 32'h1122_3344);

    // One byte per lane from requester 1.
    for (int i = 0; i < 4; i++) begin
      txn(1, 32'h20 + i, OPW, SB, 32'h0000_00A5, lat, e);
      chk("byte_web", t_web, 4'b1000 >> i);
      chk("byte_dinb", t_dinb, 32'hA5A5_A5A5);
    end
    txn(1, 32'h20, ORS, SW, 32'h0, lat, e);
    chk("byte_rd", t_dout, 32'hA5A5_A5A5);

    // Misaligned writes, aligned halfword in upper offset, then untouched word.
    txn(0, 32'h31, OPW, SH, 32'h0000_BEEF, lat, e);
    chk("mis_h_web", t_web, 4'b0000);
    chk("mis_h_err", e, 1);
    chk("mis_h_lat", lat, 1);
    txn(0, 32'h32, OPW, SW, 32'hCAFE_F00D, lat, e);
    chk("mis_w_web", t_web, 4'b0000);
    chk("mis_w_err", e, 1);
    txn(0, 32'h30, ORS, SW, 32'h0, lat, e);
    chk("mis_rd", t_dout, 32'h0000_0000);
    chk("mis_rd_err", e, 0);
    txn(1, 32'h36, OPW, SH, 32'h0000_1234, lat, e);
    chk("half_hi_web", t_web, 4'b0011);
    chk("half_hi_dinb", t_dinb, 32'h3412_3412);

    // Range boundaries.
    txn(0, 32'h0200_0100, OPW, SW, 32'h0BAD_0BAD, lat, e);
    chk("oor_web", t_web, 4'b0000);
    chk("oor_err", e, 0);
    chk("oor_lat", lat, 1);
    txn(0, BRAM_END, OPW, SW, 32'h0102_0304, lat, e);
    chk("end_web", t_web, 4'b1111);
    txn(0, BRAM_END + 4, OPW, SW, 32'h0102_0304, lat, e);
    chk("end4_web", t_web, 4'b0000);

    // Contention straight after reset: 0,1,0,1.
    pulse_reset();
    addr0 = 32'h40; memOp0 = OPW; memSize0 = SW; wdata0 = 32'hAAAA_0000;
    addr1 = 32'h44; memOp1 = OPW; memSize1 = SW; wdata1 = 32'h0000_BBBB;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 40 && order.size() < 4; i++) begin
      @(negedge clk);
      if (gnt0) order.push_back(0);
      if (gnt1) order.push_back(1);
    end
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    if (order.size() < 4) timeout_fail("tie_grants");
    else for (int i = 0; i < 4; i++) chk("tie_order", order[i], i % 2);
    repeat (3) @(posedge clk); #1;

    // Reset while a read sits in its response cycle.
    addr0 = 32'h10; memOp0 = ORS; memSize0 = SW; req0 = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (gnt0) got = 1;
    end
    if (!got) timeout_fail("rst_rd_gnt");
    @(posedge clk);
    @(posedge clk); #1;
    chk("resp_ack0", ack0, 1);
    addr1 = 32'h48; memOp1 = OPW; memSize1 = SW; wdata1 = 32'h5555_6666; req1 = 1'b1;
    reset = 1'b1;
    #1;
    chk("rst_now_ack0", ack0, 0);
    chk("rst_now_enb", enb, 0);
    chk("rst_now_web", web, 0);
    chk("rst_now_memOp", memOp, 2'b00);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_gnt0", gnt0, 1);
    chk("post_rst_gnt1", gnt1, 0);
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
